// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: matches a latched 5-bit pattern against an accepted bit stream.
// Optional macro PATTERN_SCAN_OVERLAP_EN keeps history after a hit so overlapping matches count.
module pattern_scan_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] pattern,
  input  logic [3:0] hit_limit,
  input  logic       in_valid,
  input  logic       in,
  output logic       in_ready,
  output logic       busy,
  output logic       match,
  output logic [3:0] hit_count,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state, state_nx;
  logic [4:0] pat_q, pat_nx;
  logic [3:0] lim_q, lim_nx;
  logic [3:0] hist_q, hist_nx;
  logic [2:0] fill_q, fill_nx;
  logic [3:0] cnt_nx, cnt_inc;
  logic       match_nx, done_nx, hit;

  assign in_ready = (state == SCAN);
  assign busy     = (state == SCAN) || (state == DONE);

  always_comb begin
    state_nx = state;
    pat_nx   = pat_q;
    lim_nx   = lim_q;
    hist_nx  = hist_q;
    fill_nx  = fill_q;
    cnt_nx   = hit_count;
    match_nx = 1'b0;
    done_nx  = 1'b0;
    hit      = 1'b0;
    cnt_inc  = (hit_count == 4'hF) ? hit_count : hit_count + 4'd1;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SCAN;
          pat_nx   = pattern;
          lim_nx   = hit_limit;
          hist_nx  = '0;
          fill_nx  = '0;
          cnt_nx   = '0;
        end
      end
      SCAN: begin
        // abort suppresses any hit evaluated on the same bit
        if (abort) begin
          state_nx = IDLE;
        end else if (in_valid) begin
          hit     = (fill_q == 3'd4) && ({hist_q, in} == pat_q);
          hist_nx = {hist_q[2:0], in};
          if (fill_q != 3'd4) fill_nx = fill_q + 3'd1;
          if (hit) begin
            match_nx = 1'b1;
            cnt_nx   = cnt_inc;
`ifdef PATTERN_SCAN_OVERLAP_EN
            hist_nx  = {hist_q[2:0], in};
`else
            hist_nx  = '0;
            fill_nx  = '0;
`endif
            if ((lim_q != 4'd0) && (cnt_inc == lim_q)) begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pat_q     <= '0;
      lim_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      hit_count <= '0;
      match     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      pat_q     <= pat_nx;
      lim_q     <= lim_nx;
      hist_q    <= hist_nx;
      fill_q    <= fill_nx;
      hit_count <= cnt_nx;
      match     <= match_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed-vector bench for pattern_scan_ctrl; expectations follow PATTERN_SCAN_OVERLAP_EN.
module tb_pattern_scan_ctrl;

`ifdef PATTERN_SCAN_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  localparam logic [4:0] P = 5'b11011;
  localparam logic [3:0] H = OVL ? 4'd2 : 4'd1;

  logic       clk = 1'b0;
  logic       reset, start, abort, in_valid, in;
  logic [4:0] pattern;
  logic [3:0] hit_limit;
  logic       in_ready, busy, match, done;
  logic [3:0] hit_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .hit_limit(hit_limit), .in_valid(in_valid), .in(in),
    .in_ready(in_ready), .busy(busy), .match(match), .hit_count(hit_count), .done(done)
  );

  typedef struct {
    logic       rst, st, ab;
    logic [4:0] pat;
    logic [3:0] lim;
    logic       iv, din;
    logic       rdy, bsy, m;
    logic [3:0] hc;
    logic       d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, st, ab, input logic [4:0] pat, input logic [3:0] lim,
                     input logic iv, din, rdy, bsy, m, input logic [3:0] hc, input logic d);
    vec_t v;
    v.rst = rst; v.st = st; v.ab = ab; v.pat = pat; v.lim = lim; v.iv = iv; v.din = din;
    v.rdy = rdy; v.bsy = bsy; v.m = m; v.hc = hc; v.d = d;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic rst, st, ab, input logic [4:0] pat, input logic [3:0] lim,
                      input logic iv, din);
    reset = rst; start = st; abort = ab; pattern = pat; hit_limit = lim;
    in_valid = iv; in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hits;
    int done_at;
    reset = 1'b0; start = 1'b0; abort = 1'b0; pattern = '0; hit_limit = '0;
    in_valid = 1'b0; in = 1'b0;

    // Reset state, then overlapping-stream scan with unlimited hits
    add(0,0,0,0,0,0,0, 0,0,0,0,0);
    add(1,1,0,P,0,0,0, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,0,0,0);
    add(1,0,0,P,0,1,0, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,1,1,0);
    add(1,0,0,P,0,1,0, 1,1,0,1,0);
    add(1,0,0,P,0,1,1, 1,1,0,1,0);
    add(1,0,0,P,0,1,1, 1,1,OVL,H,0);
    add(1,0,1,P,0,0,0, 0,0,0,H,0);
    add(1,0,1,P,0,1,1, 0,0,0,H,0);
    // limit = 1; pattern/limit inputs change after start, start ignored in SCAN/DONE
    add(1,1,0,P,1,0,0, 1,1,0,0,0);
    add(1,0,0,0,0,1,1, 1,1,0,0,0);
    add(1,0,0,0,0,1,1, 1,1,0,0,0);
    add(1,0,0,0,0,1,0, 1,1,0,0,0);
    add(1,0,0,0,0,1,1, 1,1,0,0,0);
    add(1,1,0,0,0,1,1, 0,1,1,1,1);
    add(1,1,1,0,0,1,1, 0,0,0,1,0);
    add(1,0,0,0,0,0,0, 0,0,0,1,0);
    // abort together with the completing bit
    add(1,1,0,P,0,0,0, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,0,0,0);
    add(1,0,0,P,0,1,0, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,0,0,0);
    add(1,0,1,P,0,1,1, 0,0,0,0,0);
    // in_valid toggling; invalid cycles carry data that would break the pattern if shifted
    add(1,1,0,P,0,0,0, 1,1,0,0,0);
    add(1,0,0,0,0,1,1, 1,1,0,0,0);
    add(1,0,0,0,0,0,0, 1,1,0,0,0);
    add(1,0,0,0,0,1,1, 1,1,0,0,0);
    add(1,0,0,0,0,0,1, 1,1,0,0,0);
    add(1,0,0,0,0,1,0, 1,1,0,0,0);
    add(1,0,0,0,0,0,0, 1,1,0,0,0);
    add(1,0,0,0,0,1,1, 1,1,0,0,0);
    add(1,0,0,0,0,0,0, 1,1,0,0,0);
    add(1,0,0,0,0,1,1, 1,1,1,1,0);
    add(1,0,0,0,0,0,0, 1,1,0,1,0);
    add(1,0,1,0,0,0,0, 0,0,0,1,0);
    // reset mid-scan with competing inputs, then fresh scan must not reuse stale history
    add(1,1,0,P,0,0,0, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,0,0,0);
    add(1,0,0,P,0,1,0, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,0,0,0);
    add(0,1,1,P,0,1,1, 0,0,0,0,0);
    add(1,1,0,P,0,0,0, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,0,0,0);
    add(1,0,0,P,0,1,0, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,0,0,0);
    add(1,0,0,P,0,1,1, 1,1,1,1,0);
    add(1,0,1,P,0,0,0, 0,0,0,1,0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].ab, vecs[i].pat, vecs[i].lim, vecs[i].iv, vecs[i].din);
      chk("in_ready",  i, {3'b0, in_ready}, {3'b0, vecs[i].rdy});
      chk("busy",      i, {3'b0, busy},     {3'b0, vecs[i].bsy});
      chk("match",     i, {3'b0, match},    {3'b0, vecs[i].m});
      chk("hit_count", i, hit_count,        vecs[i].hc);
      chk("done",      i, {3'b0, done},     {3'b0, vecs[i].d});
    end

    // hit_count saturation on a long run of zeros against pattern 00000
    step(1,1,0,5'b00000,4'd0,0,0);
    hits = 0;
    for (int b = 0; b < 80; b++) begin
      step(1,0,0,5'b00000,4'd0,1,0);
      if (match) hits++;
    end
    chk("sat_hits", 0, hits[3:0] ^ 4'(hits >> 4), (OVL ? 4'(76) ^ 4'(76 >> 4) : 4'(16) ^ 4'(16 >> 4)));
    chk("sat_count", 0, hit_count, 4'hF);
    chk("sat_done", 0, {3'b0, done}, 4'd0);
    step(1,0,1,5'b00000,4'd0,0,0);
    chk("sat_hold", 0, hit_count, 4'hF);

    // limit = 3 on zeros: completion bit index depends on overlap mode
    step(1,1,0,5'b00000,4'd3,0,0);
    done_at = 0;
    for (int b = 1; b <= 40; b++) begin
      if (done_at == 0) begin
        step(1,0,0,5'b00000,4'd0,1,0);
        if (done) begin
          done_at = b;
          chk("lim3_match", b, {3'b0, match},    4'd1);
          chk("lim3_count", b, hit_count,        4'd3);
          chk("lim3_ready", b, {3'b0, in_ready}, 4'd0);
          chk("lim3_busy",  b, {3'b0, busy},     4'd1);
        end
      end
    end
    chk("lim3_done_bit", 0, 4'(done_at), OVL ? 4'd7 : 4'd15);
    step(1,0,0,5'b00000,4'd0,1,0);
    chk("lim3_idle_busy", 0, {3'b0, busy}, 4'd0);
    chk("lim3_idle_done", 0, {3'b0, done}, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
